// File: rtl/posit_pkg.sv
// Shared definitions for the posit operand decoder.
//   N, ES            : posit word width and exponent field width
//   SCALE_W, FRAC_W  : widths of the decoded scale and significand
//   CNT_W            : width of the regime run-length count
//   POSIT_ZERO/NAR   : the two special encodings
//   decoded_t        : one decoded operand as presented downstream
package posit_pkg;

  localparam int N       = 32;
  localparam int ES      = 2;
  localparam int SCALE_W = 9;
  localparam int FRAC_W  = 28;
  localparam int CNT_W   = 5;

  localparam logic [N-1:0] POSIT_ZERO = '0;
  localparam logic [N-1:0] POSIT_NAR  = {1'b1, {(N-1){1'b0}}};

  typedef struct packed {
    logic                       sign;
    logic signed [SCALE_W-1:0]  scale;
    logic        [FRAC_W-1:0]   frac;
    logic                       zero;
    logic                       inf;
  } decoded_t;

endpackage

// File: rtl/posit_decode_pipe_if.sv
// Operand stream into the decoder and decoded stream out of it.
//   in_posit/in_valid/in_ready : input handshake (posit word)
//   out_*/out_valid/out_ready  : decoded operand handshake
// slave  : the decoder side
// master : the producer/consumer side
interface posit_decode_pipe_if;
  import posit_pkg::*;

  logic [N-1:0]              in_posit;
  logic                      in_valid;
  logic                      in_ready;
  logic                      out_sign;
  logic signed [SCALE_W-1:0] out_scale;
  logic [FRAC_W-1:0]         out_frac;
  logic                      out_zero;
  logic                      out_inf;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  in_posit, in_valid, out_ready,
    output in_ready, out_sign, out_scale, out_frac, out_zero, out_inf, out_valid
  );

  modport master (
    output in_posit, in_valid, out_ready,
    input  in_ready, out_sign, out_scale, out_frac, out_zero, out_inf, out_valid
  );

endinterface

// File: rtl/posit_run_count.sv
// Regime run-length counter.
//   i_bits    : magnitude below the sign bit, MSB first
//   o_count   : number of leading bits equal to i_bits[W-1] (W if all equal)
//   o_run_bit : the bit value forming the run
module posit_run_count #(
  parameter int W     = 31,
  parameter int CNT_W = 5
) (
  input  logic [W-1:0]     i_bits,
  output logic [CNT_W-1:0] o_count,
  output logic             o_run_bit
);

  logic [W-1:0] w_x;

  assign o_run_bit = i_bits[W-1];

  // Bits that differ from the run bit become 1, so the run length is the
  // leading-zero count of w_x. Scanning upward lets the highest hit win.
  always_comb begin
    w_x     = i_bits ^ {W{i_bits[W-1]}};
    o_count = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (w_x[i]) o_count = CNT_W'(W - 1 - i);
    end
  end

endmodule

// File: rtl/posit_decode_pipe.sv
// Two-stage posit operand decoder with valid/ready flow control.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of posit_decode_pipe_if
// Stage 1 captures sign, magnitude and special-value flags.
// Stage 2 decodes regime, exponent and fraction into scale/significand.
// in_ready depends combinationally on out_ready only.
module posit_decode_pipe #(
  parameter int N  = posit_pkg::N,
  parameter int ES = posit_pkg::ES
) (
  input  logic             clk,
  input  logic             rst_n,
  posit_decode_pipe_if.slave bus
);
  import posit_pkg::*;

  localparam int STAGES = 2;
  // Bits kept after dropping the regime: ES exponent bits + fraction bits.
  localparam int REM_W  = ES + FRAC_W - 1;

  logic [STAGES:1]           r_vld_pipe;
  logic                      r_s1_sign;
  logic                      r_s1_zero;
  logic                      r_s1_inf;
  logic [N-2:0]              r_s1_mag;
  decoded_t                  r_out;

  logic                      w_s1_adv;
  logic                      w_s2_adv;
  logic [CNT_W-1:0]          w_m;
  logic                      w_run_bit;
  logic [REM_W-1:0]          w_fld;
  logic [ES-1:0]             w_e;
  logic signed [SCALE_W-1:0] w_m_s;
  logic signed [SCALE_W-1:0] w_k;
  logic signed [SCALE_W-1:0] w_scale;
  decoded_t                  w_dec;

  assign w_s2_adv = !r_vld_pipe[2] || bus.out_ready;
  assign w_s1_adv = !r_vld_pipe[1] || w_s2_adv;

  posit_run_count #(.W(N-1), .CNT_W(CNT_W)) u_run (
    .i_bits    (r_s1_mag),
    .o_count   (w_m),
    .o_run_bit (w_run_bit)
  );

  // Shift out the regime and its terminating bit; a run reaching bit 0
  // shifts everything out, giving e = 0 and fraction = 0.
  assign w_fld   = REM_W'((r_s1_mag << ({1'b0, w_m} + 6'd1)) >> (N - 1 - REM_W));
  assign w_e     = w_fld[REM_W-1 -: ES];
  assign w_m_s   = signed'(SCALE_W'(w_m));
  assign w_k     = w_run_bit ? (w_m_s - SCALE_W'(1)) : (-w_m_s);
  assign w_scale = (w_k <<< ES) + signed'(SCALE_W'(w_e));

  always_comb begin
    w_dec      = '0;
    w_dec.zero = r_s1_zero;
    w_dec.inf  = r_s1_inf;
    if (!(r_s1_zero || r_s1_inf)) begin
      w_dec.sign  = r_s1_sign;
      w_dec.scale = w_scale;
      w_dec.frac  = {1'b1, w_fld[FRAC_W-2:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_mag   <= '0;
      r_out      <= '0;
    end else begin
      if (w_s1_adv) begin
        r_vld_pipe[1] <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_sign <= bus.in_posit[N-1];
          r_s1_zero <= (bus.in_posit == POSIT_ZERO);
          r_s1_inf  <= (bus.in_posit == POSIT_NAR);
          // Low bits of the two's-complement negation; the top bit is
          // always 0 for every non-NaR operand.
          r_s1_mag  <= bus.in_posit[N-1] ? (~bus.in_posit[N-2:0] + 1'b1)
                                         : bus.in_posit[N-2:0];
        end
      end
      if (w_s2_adv) begin
        r_vld_pipe[2] <= r_vld_pipe[1];
        if (r_vld_pipe[1]) r_out <= w_dec;
      end
    end
  end

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_vld_pipe[2];
  assign bus.out_sign  = r_out.sign;
  assign bus.out_scale = r_out.scale;
  assign bus.out_frac  = r_out.frac;
  assign bus.out_zero  = r_out.zero;
  assign bus.out_inf   = r_out.inf;

endmodule
